// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - AXI read address/data channel bundle shared by the I/D read arbiter
interface axi_read_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin I/D line-fill arbiter over one AXI read channel
// One INCR burst outstanding at a time; beats are steered back to the granted side one cycle later.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  output logic                  i_resp_valid,
  output logic                  i_resp_last,
  output logic                  d_resp_valid,
  output logic                  d_resp_last,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  axi_read_arbiter_if.master    axi
);
  localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN * 8 - 1);
  localparam logic                  GRANT_I   = 1'b0;
  localparam logic                  GRANT_D   = 1'b1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_next;
  logic                  grant, last_grant, pick;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            beat_cnt;
  logic                  arvalid, rready;
  logic                  beat, beat_last;

  // On a tie the side that did not win last time is picked.
  assign pick      = (i_req_valid && d_req_valid) ? ~last_grant : d_req_valid;
  assign beat      = (state == DATA) && axi.m_axi_rvalid;
  assign beat_last = beat && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    case (state)
      IDLE: begin
        i_req_ready = i_req_valid && (pick == GRANT_I);
        d_req_ready = d_req_valid && (pick == GRANT_D);
        if (i_req_ready || d_req_ready) state_next = ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (axi.m_axi_arready) state_next = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (beat_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep the request handshake quiet while reset is held, even in IDLE.
    if (!reset) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= GRANT_I;
      last_grant <= GRANT_D;
      addr       <= '0;
      beat_cnt   <= '0;
    end else begin
      if (i_req_ready || d_req_ready) begin
        grant    <= d_req_ready;
        addr     <= (d_req_ready ? d_req_addr : i_req_addr) & LINE_MASK;
        beat_cnt <= '0;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (beat_last) last_grant <= grant;
      end
    end
  end

  // Burst length is counted locally; rlast and rid only feed the error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_resp_valid <= 1'b0;
      i_resp_last  <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_last  <= 1'b0;
      resp_err     <= 1'b0;
      resp_data    <= '0;
    end else begin
      i_resp_valid <= beat && (grant == GRANT_I);
      d_resp_valid <= beat && (grant == GRANT_D);
      i_resp_last  <= beat_last && (grant == GRANT_I);
      d_resp_last  <= beat_last && (grant == GRANT_D);
      resp_err     <= beat && ((axi.m_axi_rresp != 2'b00) ||
                               (axi.m_axi_rid != ID_WIDTH'(grant)) ||
                               (axi.m_axi_rlast != (beat_cnt == LAST_BEAT)));
      if (beat) resp_data <= axi.m_axi_rdata;
    end
  end

  assign axi.m_axi_arid    = ID_WIDTH'(grant);
  assign axi.m_axi_araddr  = addr;
  assign axi.m_axi_arlen   = LAST_BEAT;
  assign axi.m_axi_arsize  = 3'd3;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arvalid = arvalid;
  assign axi.m_axi_rready  = rready;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;
  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int BL  = 8;
  localparam logic [AW-1:0] LMASK = ~AW'(BL * 8 - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req_valid = 1'b0, d_req_valid = 1'b0;
  logic          i_req_ready, d_req_ready;
  logic [AW-1:0] i_req_addr = '0, d_req_addr = '0;
  logic          i_resp_valid, i_resp_last, d_resp_valid, d_resp_last;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  axi_read_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_last(i_resp_last),
    .d_resp_valid(d_resp_valid), .d_resp_last(d_resp_last),
    .resp_data(resp_data), .resp_err(resp_err),
    .axi(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed response beats and request acceptances
  int            m_cyc[$];
  logic          m_i[$], m_d[$], m_last[$], m_err[$];
  logic [DW-1:0] m_data[$];
  int            a_cyc[$], a_side[$];

  always @(negedge clk) begin
    #2;
    if (i_resp_valid || d_resp_valid) begin
      m_cyc.push_back(cyc);
      m_i.push_back(i_resp_valid);
      m_d.push_back(d_resp_valid);
      m_last.push_back(i_resp_last | d_resp_last);
      m_err.push_back(resp_err);
      m_data.push_back(resp_data);
    end
    if (i_req_valid && i_req_ready) begin a_cyc.push_back(cyc); a_side.push_back(0); end
    if (d_req_valid && d_req_ready) begin a_cyc.push_back(cyc); a_side.push_back(1); end
  end

  // Beats handed to the DUT by the memory model
  int             b_cyc[$];
  logic [DW-1:0]  b_data[$];
  logic [1:0]     b_resp[$];
  logic [IDW-1:0] b_rid[$];
  logic           b_last[$];

  int             s_ar_first, s_ar_hs, s_last_cyc, s_timeout, s_ar_unstable, s_rready_bad;
  logic           s_rready_after;
  logic [IDW-1:0] s_arid;
  logic [AW-1:0]  s_araddr;
  logic [12:0]    s_arconst;
  logic [5:0]     gap_pat = 6'b011001;

  function automatic logic exp_err(int idx, logic [1:0] rr, logic [IDW-1:0] rid, logic rl, int side);
    return (rr != 2'd0) || (rid != IDW'(side)) || (rl != (idx == BL - 1));
  endfunction

  function automatic void clear_mon();
    m_cyc.delete(); m_i.delete(); m_d.delete(); m_last.delete(); m_err.delete(); m_data.delete();
  endfunction

  // Memory-side model: accepts one AR after ar_delay stall cycles and returns nbeats beats.
  task automatic serve_burst(input int ar_delay, input int gap_mode, input int e_rresp,
                             input int e_rlast, input int e_rid, input int nbeats,
                             input bit keep, input bit seq_data);
    int t, k, beat;
    logic rv;
    b_cyc.delete(); b_data.delete(); b_resp.delete(); b_rid.delete(); b_last.delete();
    s_timeout = 0; s_ar_unstable = 0; s_rready_bad = 0;
    s_ar_first = -1; s_ar_hs = -1; s_last_cyc = -1; s_rready_after = 1'b0;
    t = 0;
    @(negedge clk); #1;
    while (!bus.m_axi_arvalid) begin
      t++;
      if (t > 50) begin s_timeout = 1; return; end
      @(negedge clk); #1;
    end
    s_ar_first = cyc;
    s_arid     = bus.m_axi_arid;
    s_araddr   = bus.m_axi_araddr;
    s_arconst  = {bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst};
    if (!keep) begin i_req_valid = 1'b0; d_req_valid = 1'b0; end
    k = 0;
    forever begin
      if (!bus.m_axi_arvalid || bus.m_axi_araddr !== s_araddr || bus.m_axi_arid !== s_arid ||
          bus.m_axi_rready || i_req_ready || d_req_ready)
        s_ar_unstable++;
      if (k == ar_delay) break;
      k++;
      @(negedge clk); #1;
    end
    bus.m_axi_arready = 1'b1;
    s_ar_hs = cyc;
    beat = 0; t = 0;
    @(negedge clk); #1;
    bus.m_axi_arready = 1'b0;
    while (beat < nbeats) begin
      if (!bus.m_axi_rready) s_rready_bad++;
      case (gap_mode)
        0:       rv = 1'b1;
        1:       rv = 1'($urandom_range(0, 1));
        default: rv = gap_pat[(cyc - s_ar_hs - 1) % 6];
      endcase
      bus.m_axi_rvalid = rv;
      if (rv) begin
        bus.m_axi_rdata = seq_data ? DW'(beat) : {$urandom, $urandom};
        bus.m_axi_rresp = (beat == e_rresp) ? 2'd2 : 2'd0;
        bus.m_axi_rid   = (beat == e_rid) ? (s_arid ^ IDW'(1)) : s_arid;
        bus.m_axi_rlast = (beat == BL - 1) ^ (beat == e_rlast);
        if (bus.m_axi_rready) begin
          b_cyc.push_back(cyc);
          b_data.push_back(bus.m_axi_rdata);
          b_resp.push_back(bus.m_axi_rresp);
          b_rid.push_back(bus.m_axi_rid);
          b_last.push_back(bus.m_axi_rlast);
          s_last_cyc = cyc;
          beat++;
        end
      end
      t++;
      if (t > 200) begin s_timeout = 1; break; end
      @(negedge clk); #1;
    end
    s_rready_after = bus.m_axi_rready;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'd0;
    #2;
  endtask

  task automatic test_reset();
    logic [IDW+AW+DW+8:0] ov;
    reset = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    ov = {i_req_ready, d_req_ready, i_resp_valid, i_resp_last, d_resp_valid, d_resp_last,
          resp_err, bus.m_axi_arvalid, bus.m_axi_rready, resp_data, bus.m_axi_araddr, bus.m_axi_arid};
    checks++;
    if (ov !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", ov); end
    checks++;
    if ({bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst} !== {8'd7, 3'd3, 2'b01}) begin
      failures++;
      $display("FAIL reset_ar_const got=%h exp=%h", {bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst},
               {8'd7, 3'd3, 2'b01});
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single_i();
    logic [DW+3:0] ov, ev;
    clear_mon(); a_cyc.delete(); a_side.delete();
    i_req_addr = 64'h1004; i_req_valid = 1'b1;
    serve_burst(0, 0, -1, -1, -1, BL, 1'b0, 1'b1);
    checks++;
    if (s_timeout != 0 || a_cyc.size() != 1 || s_ar_first != a_cyc[0] + 1) begin
      failures++;
      $display("FAIL single_ar_timing timeout=%0d accepts=%0d ar_cycle=%0d exp_ar_cycle=%0d",
               s_timeout, a_cyc.size(), s_ar_first, (a_cyc.size() > 0) ? a_cyc[0] + 1 : -1);
    end
    checks++;
    if ({s_arid, s_araddr, s_arconst} !== {IDW'(0), 64'h1000, 8'd7, 3'd3, 2'b01}) begin
      failures++;
      $display("FAIL single_ar_fields got=%h/%h/%h exp=0/1000/%h", s_arid, s_araddr, s_arconst,
               {8'd7, 3'd3, 2'b01});
    end
    checks++;
    if (s_rready_bad != 0 || s_rready_after !== 1'b0) begin
      failures++;
      $display("FAIL single_rready low_cycles=%0d after_last=%b exp=0/0", s_rready_bad, s_rready_after);
    end
    checks++;
    if (m_cyc.size() != BL) begin
      failures++; $display("FAIL single_beats got=%0d exp=%0d", m_cyc.size(), BL);
    end
    for (int j = 0; j < m_cyc.size() && j < b_cyc.size(); j++) begin
      ov = {m_i[j], m_d[j], m_last[j], m_err[j], m_data[j]};
      ev = {1'b1, 1'b0, 1'(j == BL - 1), 1'b0, DW'(j)};
      checks++;
      if (ov !== ev || m_cyc[j] != b_cyc[j] + 1) begin
        failures++;
        $display("FAIL single_beat%0d got=%h@%0d exp=%h@%0d", j, ov, m_cyc[j], ev, b_cyc[j] + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DW+3:0] ov, ev;
    int side;
    reset = 1'b0;
    i_req_addr = {$urandom, $urandom}; d_req_addr = {$urandom, $urandom};
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    a_cyc.delete(); a_side.delete();
    @(negedge clk); #1;
    reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      side = r % 2;
      clear_mon();
      serve_burst($urandom_range(0, 3), 1, -1, -1, -1, BL, r < 3, 1'b0);
      checks++;
      if (s_timeout != 0 || a_cyc.size() != ((r < 3) ? r + 2 : r + 1) || a_side[r] != side ||
          s_ar_first != a_cyc[r] + 1) begin
        failures++;
        $display("FAIL rr_grant round=%0d timeout=%0d accepts=%0d side=%0d exp_side=%0d ar_cycle=%0d",
                 r, s_timeout, a_cyc.size(), (a_side.size() > r) ? a_side[r] : -1, side, s_ar_first);
      end
      checks++;
      if ({s_arid, s_araddr} !== {IDW'(side), ((side == 0) ? i_req_addr : d_req_addr) & LMASK}) begin
        failures++;
        $display("FAIL rr_ar round=%0d got=%h/%h exp=%0d/%h", r, s_arid, s_araddr, side,
                 ((side == 0) ? i_req_addr : d_req_addr) & LMASK);
      end
      if (r < 3) begin
        checks++;
        if (a_cyc.size() < r + 2 || a_cyc[r + 1] != s_last_cyc + 1) begin
          failures++;
          $display("FAIL rr_next_accept round=%0d got=%0d exp=%0d", r,
                   (a_cyc.size() > r + 1) ? a_cyc[r + 1] : -1, s_last_cyc + 1);
        end
      end
      checks++;
      if (m_cyc.size() != BL || s_rready_bad != 0) begin
        failures++;
        $display("FAIL rr_beats round=%0d got=%0d exp=%0d rready_low=%0d", r, m_cyc.size(), BL, s_rready_bad);
      end
      for (int j = 0; j < m_cyc.size() && j < b_cyc.size(); j++) begin
        ov = {m_i[j], m_d[j], m_last[j], m_err[j], m_data[j]};
        ev = {1'(side == 0), 1'(side == 1), 1'(j == BL - 1), exp_err(j, b_resp[j], b_rid[j], b_last[j], side), b_data[j]};
        checks++;
        if (ov !== ev || m_cyc[j] != b_cyc[j] + 1) begin
          failures++;
          $display("FAIL rr_beat r%0d b%0d got=%h@%0d exp=%h@%0d", r, j, ov, m_cyc[j], ev, b_cyc[j] + 1);
        end
      end
    end
  endtask

  task automatic test_ar_stall();
    int side;
    side = $urandom_range(0, 1);
    clear_mon();
    if (side == 0) begin i_req_addr = {$urandom, $urandom}; i_req_valid = 1'b1; end
    else begin d_req_addr = {$urandom, $urandom}; d_req_valid = 1'b1; end
    serve_burst(4, 0, -1, -1, -1, BL, 1'b0, 1'b0);
    checks++;
    if (s_ar_unstable != 0 || s_ar_hs != s_ar_first + 4 || s_arid !== IDW'(side)) begin
      failures++;
      $display("FAIL stall_ar unstable=%0d stall=%0d exp=4 arid=%0d exp_arid=%0d", s_ar_unstable,
               s_ar_hs - s_ar_first, s_arid, side);
    end
    checks++;
    if (s_timeout != 0 || b_cyc.size() != BL || b_cyc[0] != s_ar_hs + 1 || s_rready_bad != 0) begin
      failures++;
      $display("FAIL stall_first_beat got=%0d exp=%0d rready_low=%0d", (b_cyc.size() > 0) ? b_cyc[0] : -1,
               s_ar_hs + 1, s_rready_bad);
    end
  endtask

  task automatic test_rvalid_gaps();
    logic [DW+3:0] ov, ev;
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      i_req_addr = {$urandom, $urandom}; i_req_valid = 1'b1;
      serve_burst(0, (r == 0) ? 2 : 1, -1, -1, -1, BL, 1'b0, 1'b0);
      checks++;
      if (s_timeout != 0 || m_cyc.size() != BL || s_rready_bad != 0 || s_rready_after !== 1'b0) begin
        failures++;
        $display("FAIL gaps_count run=%0d got=%0d exp=%0d rready_low=%0d rready_after=%b", r, m_cyc.size(), BL,
                 s_rready_bad, s_rready_after);
      end
      for (int j = 0; j < m_cyc.size() && j < b_cyc.size(); j++) begin
        ov = {m_i[j], m_d[j], m_last[j], m_err[j], m_data[j]};
        ev = {1'b1, 1'b0, 1'(j == BL - 1), 1'b0, b_data[j]};
        checks++;
        if (ov !== ev || m_cyc[j] != b_cyc[j] + 1) begin
          failures++;
          $display("FAIL gaps_beat run%0d b%0d got=%h@%0d exp=%h@%0d", r, j, ov, m_cyc[j], ev, b_cyc[j] + 1);
        end
      end
    end
  endtask

  task automatic test_errors();
    int e_rr[3] = '{3, -1, -1};
    int e_rl[3] = '{-1, 5, -1};
    int e_id[3] = '{-1, -1, 2};
    int side, nerr, eidx;
    logic [DW+3:0] ov, ev;
    for (int c = 0; c < 3; c++) begin
      side = (c == 2) ? 0 : int'($urandom_range(0, 1));
      clear_mon();
      if (side == 0) begin i_req_addr = {$urandom, $urandom}; i_req_valid = 1'b1; end
      else begin d_req_addr = {$urandom, $urandom}; d_req_valid = 1'b1; end
      serve_burst($urandom_range(0, 2), 1, e_rr[c], e_rl[c], e_id[c], BL, 1'b0, 1'b0);
      nerr = 0; eidx = -1;
      for (int j = 0; j < m_err.size(); j++) if (m_err[j]) begin nerr++; eidx = j; end
      checks++;
      if (m_cyc.size() != BL || nerr != 1 || eidx != e_rr[c] + e_rl[c] + e_id[c] + 2) begin
        failures++;
        $display("FAIL err_case%0d beats=%0d exp=%0d flagged=%0d at=%0d exp_at=%0d", c, m_cyc.size(), BL,
                 nerr, eidx, e_rr[c] + e_rl[c] + e_id[c] + 2);
      end
      for (int j = 0; j < m_cyc.size() && j < b_cyc.size(); j++) begin
        ov = {m_i[j], m_d[j], m_last[j], m_err[j], m_data[j]};
        ev = {1'(side == 0), 1'(side == 1), 1'(j == BL - 1), exp_err(j, b_resp[j], b_rid[j], b_last[j], side), b_data[j]};
        checks++;
        if (ov !== ev || m_cyc[j] != b_cyc[j] + 1) begin
          failures++;
          $display("FAIL err_beat c%0d b%0d got=%h@%0d exp=%h@%0d", c, j, ov, m_cyc[j], ev, b_cyc[j] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [IDW+AW+DW+8:0] ov;
    logic [DW+3:0] rv, ev;
    int bad;
    i_req_addr = {$urandom, $urandom}; i_req_valid = 1'b1;
    serve_burst(1, 0, -1, -1, -1, 4, 1'b0, 1'b0);
    // Beat 4 is offered and reset drops between clock edges.
    i_req_valid = 1'b1;
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rid = '0; bus.m_axi_rdata = {$urandom, $urandom};
    reset = 1'b0;
    #1;
    ov = {i_req_ready, d_req_ready, i_resp_valid, i_resp_last, d_resp_valid, d_resp_last,
          resp_err, bus.m_axi_arvalid, bus.m_axi_rready, resp_data, bus.m_axi_araddr, bus.m_axi_arid};
    checks++;
    if (ov !== '0) begin failures++; $display("FAIL midreset_outputs got=%h exp=0", ov); end
    @(negedge clk); #1;
    i_req_valid = 1'b0;
    reset = 1'b1;
    clear_mon();
    bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.m_axi_rready || bus.m_axi_arvalid) bad++;
    end
    #2;
    checks++;
    if (bad != 0 || m_cyc.size() != 0) begin
      failures++;
      $display("FAIL midreset_idle busy_cycles=%0d resp_beats=%0d exp=0/0", bad, m_cyc.size());
    end
    bus.m_axi_rvalid = 1'b0;
    i_req_addr = {$urandom, $urandom}; d_req_addr = {$urandom, $urandom};
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    serve_burst(0, 1, -1, -1, -1, BL, 1'b0, 1'b0);
    checks++;
    if (s_timeout != 0 || {s_arid, s_araddr} !== {IDW'(0), i_req_addr & LMASK}) begin
      failures++;
      $display("FAIL midreset_new_ar timeout=%0d got=%h/%h exp=0/%h", s_timeout, s_arid, s_araddr,
               i_req_addr & LMASK);
    end
    checks++;
    if (m_cyc.size() != BL) begin
      failures++; $display("FAIL midreset_beats got=%0d exp=%0d", m_cyc.size(), BL);
    end
    for (int j = 0; j < m_cyc.size() && j < b_cyc.size(); j++) begin
      rv = {m_i[j], m_d[j], m_last[j], m_err[j], m_data[j]};
      ev = {1'b1, 1'b0, 1'(j == BL - 1), 1'b0, b_data[j]};
      checks++;
      if (rv !== ev || m_cyc[j] != b_cyc[j] + 1) begin
        failures++;
        $display("FAIL midreset_beat%0d got=%h@%0d exp=%h@%0d", j, rv, m_cyc[j], ev, b_cyc[j] + 1);
      end
    end
  endtask

  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'd0;
    bus.m_axi_rid     = '0;
    bus.m_axi_rlast   = 1'b0;
    test_reset();
    test_single_i();
    test_round_robin();
    test_ar_stall();
    test_rvalid_gaps();
    test_errors();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end
endmodule
